registered_gate_cluster: RTL and testbench
==========================================

Name: registered_gate_cluster

Overview:
- Bitwise gate unit computing 2-input AND, 2-input NAND and 4-input NOR over WIDTH-bit operand vectors.
- Provides both combinational results and a registered, valid-qualified copy with 1-cycle latency.
- Keeps a saturating count of accepted samples where the 4-input NOR fires.
- Used as a small glue-logic/decode primitive in datapath control.

Parameters:
- WIDTH, 1, bit width of every operand and result vector (legal: 1..64).
- CNT_W, 8, width of the NOR-hit counter (legal: 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands a/b/c/d are valid this cycle; sample is accepted.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- C  input  WIDTH  operand C (NOR only).
- D  input  WIDTH  operand D (NOR only).
- Y_and  output  WIDTH  combinational A & B.
- Y_nand  output  WIDTH  combinational ~(A & B).
- Y_nor_4  output  WIDTH  combinational ~(A | B | C | D).
- out_valid  output  1  registered outputs hold a freshly accepted sample.
- Q_and  output  WIDTH  registered Y_and.
- Q_nand  output  WIDTH  registered Y_nand.
- Q_nor_4  output  WIDTH  registered Y_nor_4.
- nor_hit_cnt  output  CNT_W  number of accepted samples with any Y_nor_4 bit set.

Behaviour:
- Combinational outputs: pure bitwise functions of current inputs, no clock dependence, independent of rst and in_valid. They are valid in the same cycle the inputs change.
- Per bit i: Y_and[i]=A[i]&B[i]; Y_nand[i]=~Y_and[i]; Y_nor_4[i]=~(A[i]|B[i]|C[i]|D[i]).
- Invariant: Y_nand == ~Y_and at all times.
- X/Z inputs are not handled specially; standard Verilog operator semantics apply.
- Registered path, on each rising clk edge:
  - If rst: Q_and=0, Q_nand=0, Q_nor_4=0, out_valid=0, nor_hit_cnt=0. This overrides in_valid in the same cycle.
  - Else if in_valid: Q_* capture the current Y_* values, out_valid=1.
  - Else: Q_* hold their values, out_valid=0.
- Latency: exactly 1 cycle from an accepted sample to Q_* / out_valid.
- Q_nand resets to 0, not ~Q_and. The NAND relationship on Q_* applies only after the first accepted sample.
- Back-to-back in_valid: one sample is accepted per cycle; there is no backpressure.
- Counter, updated on the same edge as Q_*:
  - Increments by 1 when in_valid=1, rst=0 and |Y_nor_4 = 1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by rst.
- Reset asserted mid-stream: a sample presented in the reset cycle is discarded, out_valid is 0 on the following cycle, and the counter is 0.
- All registered outputs change only on the rising edge of clk.

Test Plan:
- WIDTH=1 truth sweep, combinational, A/B/C/D = 0000, 0110, 1011, 1101 held 10 time units each -> Y_and 0,0,0,1; Y_nand 1,1,1,0; Y_nor_4 1,0,0,0.
- Same four vectors with in_valid=1 on consecutive cycles after rst -> Q_* show identical values 1 cycle later, out_valid=1 for 4 cycles then 0, nor_hit_cnt=1.
- WIDTH=8, A=8'hF0, B=8'hCC, C=8'h0A, D=8'h01 -> Y_and=8'hC0, Y_nand=8'h3F, Y_nor_4=8'h00 (bits 1,4,5 etc. covered); then A=B=C=D=8'h00 -> Y_nor_4=8'hFF, count +1.
- in_valid=0 with changing inputs -> Q_* unchanged, out_valid=0, counter unchanged; Y_* still track the inputs.
- rst=1 asserted in the same cycle as in_valid=1, A=B=1 -> next cycle Q_and=0, out_valid=0, nor_hit_cnt=0.
- CNT_W=2, 5 accepted samples with A=B=C=D=0 -> nor_hit_cnt=3 (saturated), with no wrap to 0.

Source files
------------

// File: rtl/registered_gate_cluster.sv
// Bitwise AND / NAND / 4-input NOR gate cluster with a registered, valid-qualified
// copy of the results and a saturating count of accepted samples where the NOR fires.
module registered_gate_cluster #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Y_and,
    output logic [WIDTH-1:0] Y_nand,
    output logic [WIDTH-1:0] Y_nor_4,
    output logic             out_valid,
    output logic [WIDTH-1:0] Q_and,
    output logic [WIDTH-1:0] Q_nand,
    output logic [WIDTH-1:0] Q_nor_4,
    output logic [CNT_W-1:0] nor_hit_cnt
);

    logic [WIDTH-1:0] and_d,   and_q;
    logic [WIDTH-1:0] nand_d,  nand_q;
    logic [WIDTH-1:0] nor_d,   nor_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d,   cnt_q;

    always_comb begin
        Y_and   = A & B;
        Y_nand  = ~(A & B);
        Y_nor_4 = ~(A | B | C | D);
    end

    always_comb begin
        and_d   = and_q;
        nand_d  = nand_q;
        nor_d   = nor_q;
        valid_d = in_valid;
        cnt_d   = cnt_q;
        if (in_valid) begin
            and_d  = Y_and;
            nand_d = Y_nand;
            nor_d  = Y_nor_4;
            // Counter sticks at all-ones rather than wrapping.
            if ((|Y_nor_4) && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            and_q   <= '0;
            nand_q  <= '0;
            nor_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            and_q   <= and_d;
            nand_q  <= nand_d;
            nor_q   <= nor_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        Q_and       = and_q;
        Q_nand      = nand_q;
        Q_nor_4     = nor_q;
        out_valid   = valid_q;
        nor_hit_cnt = cnt_q;
    end

endmodule

// File: tb/tb_registered_gate_cluster.sv
// Directed-vector bench for registered_gate_cluster: WIDTH=1, WIDTH=8 and a
// CNT_W=2 instance share one clock; expected values are hand-computed.
module tb_registered_gate_cluster;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // WIDTH=1, CNT_W=8 instance
    logic       rst1, v1, a1, b1, c1, d1;
    logic       ya1, yn1, yr1, ov1, qa1, qn1, qr1;
    logic [7:0] cnt1;

    registered_gate_cluster #(.WIDTH(1), .CNT_W(8)) u_w1 (
        .clk(clk), .rst(rst1), .in_valid(v1),
        .A(a1), .B(b1), .C(c1), .D(d1),
        .Y_and(ya1), .Y_nand(yn1), .Y_nor_4(yr1),
        .out_valid(ov1), .Q_and(qa1), .Q_nand(qn1), .Q_nor_4(qr1),
        .nor_hit_cnt(cnt1)
    );

    // WIDTH=8, CNT_W=8 instance
    logic       rst_o, v8;
    logic [7:0] a8, b8, c8, d8, ya8, yn8, yr8, qa8, qn8, qr8, cnt8;
    logic       ov8;

    registered_gate_cluster #(.WIDTH(8), .CNT_W(8)) u_w8 (
        .clk(clk), .rst(rst_o), .in_valid(v8),
        .A(a8), .B(b8), .C(c8), .D(d8),
        .Y_and(ya8), .Y_nand(yn8), .Y_nor_4(yr8),
        .out_valid(ov8), .Q_and(qa8), .Q_nand(qn8), .Q_nor_4(qr8),
        .nor_hit_cnt(cnt8)
    );

    // WIDTH=1, CNT_W=2 instance for saturation
    logic       vs, as_, bs, cs, ds;
    logic       yas, yns, yrs, ovs, qas, qns, qrs;
    logic [1:0] cnts;

    registered_gate_cluster #(.WIDTH(1), .CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst_o), .in_valid(vs),
        .A(as_), .B(bs), .C(cs), .D(ds),
        .Y_and(yas), .Y_nand(yns), .Y_nor_4(yrs),
        .out_valid(ovs), .Q_and(qas), .Q_nand(qns), .Q_nor_4(qrs),
        .nor_hit_cnt(cnts)
    );

    // {A,B,C,D} vectors and expected {and,nand,nor}
    logic [3:0] vec [4]   = '{4'b0000, 4'b0110, 4'b1011, 4'b1101};
    logic [2:0] exp3 [4]  = '{3'b011, 3'b010, 3'b010, 3'b100};

    initial begin
        rst1 = 1'b1; rst_o = 1'b1;
        v1 = 1'b0; v8 = 1'b0; vs = 1'b0;
        {a1, b1, c1, d1} = 4'b0000;
        a8 = '0; b8 = '0; c8 = '0; d8 = '0;
        {as_, bs, cs, ds} = 4'b0000;
        step();
        step();

        check_val("rst_q_and",  qa1,  0);
        check_val("rst_q_nand", qn1,  0);
        check_val("rst_q_nor",  qr1,  0);
        check_val("rst_valid",  ov1,  0);
        check_val("rst_cnt",    cnt1, 0);
        check_val("rst_q_nand8", qn8, 0);
        rst1 = 1'b0; rst_o = 1'b0;

        // Combinational sweep with in_valid low: Y tracks, Q holds reset values
        for (int i = 0; i < 4; i++) begin
            {a1, b1, c1, d1} = vec[i];
            #10;
            check_val($sformatf("comb_and_%0d", i),  ya1, exp3[i][2]);
            check_val($sformatf("comb_nand_%0d", i), yn1, exp3[i][1]);
            check_val($sformatf("comb_nor_%0d", i),  yr1, exp3[i][0]);
        end
        step();
        check_val("idle_q_nand", qn1, 0);
        check_val("idle_valid",  ov1, 0);
        check_val("idle_cnt",    cnt1, 0);

        // Back-to-back accepted samples, 1-cycle latency
        for (int i = 0; i < 4; i++) begin
            {a1, b1, c1, d1} = vec[i];
            v1 = 1'b1;
            step();
            check_val($sformatf("reg_and_%0d", i),   qa1, exp3[i][2]);
            check_val($sformatf("reg_nand_%0d", i),  qn1, exp3[i][1]);
            check_val($sformatf("reg_nor_%0d", i),   qr1, exp3[i][0]);
            check_val($sformatf("reg_valid_%0d", i), ov1, 1);
        end

        // in_valid low with changing inputs: Q holds, counter holds, Y tracks
        v1 = 1'b0;
        {a1, b1, c1, d1} = 4'b0000;
        step();
        check_val("hold_valid", ov1, 0);
        check_val("hold_q_and", qa1, 1);
        check_val("hold_q_nand", qn1, 0);
        check_val("hold_q_nor", qr1, 0);
        check_val("hold_cnt",   cnt1, 1);
        check_val("hold_y_nor", yr1, 1);
        check_val("hold_y_and", ya1, 0);

        // Reset wins over in_valid in the same cycle
        {a1, b1, c1, d1} = 4'b1100;
        v1 = 1'b1; rst1 = 1'b1;
        step();
        check_val("rstv_q_and", qa1, 0);
        check_val("rstv_valid", ov1, 0);
        check_val("rstv_cnt",   cnt1, 0);
        rst1 = 1'b0; v1 = 1'b0;
        step();
        check_val("rstv_valid2", ov1, 0);
        check_val("rstv_q_and2", qa1, 0);

        // WIDTH=8 vectors
        a8 = 8'hF0; b8 = 8'hCC; c8 = 8'h0A; d8 = 8'h01; v8 = 1'b1;
        #1;
        check_val("w8_y_and",  ya8, 8'hC0);
        check_val("w8_y_nand", yn8, 8'h3F);
        check_val("w8_y_nor",  yr8, 8'h00);
        step();
        check_val("w8_q_and",  qa8, 8'hC0);
        check_val("w8_q_nand", qn8, 8'h3F);
        check_val("w8_q_nor",  qr8, 8'h00);
        check_val("w8_cnt0",   cnt8, 0);
        a8 = 8'h00; b8 = 8'h00; c8 = 8'h00; d8 = 8'h00;
        #1;
        check_val("w8_y_nor_ff", yr8, 8'hFF);
        step();
        check_val("w8_q_nor_ff",  qr8, 8'hFF);
        check_val("w8_q_nand_ff", qn8, 8'hFF);
        check_val("w8_cnt1",      cnt8, 1);
        check_val("w8_valid",     ov8, 1);
        v8 = 1'b0;
        step();
        check_val("w8_valid_off", ov8, 0);

        // CNT_W=2 saturation
        {as_, bs, cs, ds} = 4'b0000;
        vs = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val($sformatf("sat_cnt_%0d", i), cnts, (i < 3) ? i + 1 : 3);
        end
        vs = 1'b0;
        step();
        check_val("sat_cnt_hold", cnts, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
